// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    // Number of set bits in a default-width busy vector.
    function automatic logic [DEF_ADDR_W:0] popcount(
        input logic [(1 << DEF_ADDR_W)-1:0] busy
    );
        logic [DEF_ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < (1 << DEF_ADDR_W); i++) begin
            cnt = cnt + {{DEF_ADDR_W{1'b0}}, busy[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: zero-register, write-bypass and busy masking for a single index.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              busy_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    logic is_zero;
    logic bypass_hit;

    assign is_zero    = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO));
    assign bypass_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

    // Select read data and busy flag; a forwarded write also resolves the hazard.
    always_comb begin
        rd_data_o = reg_data_i;
        rd_busy_o = busy_i;
        if (is_zero) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end else if (bypass_hit) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and a pending-write scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned N_READ   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    output logic [N_READ-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic [(1 << ADDR_W)-1:0]   busy_vec,
    output logic [ADDR_W:0]            pending_cnt
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [Depth-1:0]  busy_d, busy_q;
    logic [ADDR_W:0]   pending_d, pending_q;
    logic              wr_ok;
    logic              iss_ok;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(REG_ZERO)));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

    // Register storage; reset clears every entry so reads never return X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Busy next state: flush wins; else writeback clears, then issue sets (set wins).
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_ok) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
    end

    // Count is derived from the same next state so the two registers always agree.
    if (ADDR_W == DEF_ADDR_W) begin : g_pc_pkg
        assign pending_d = popcount(busy_d);
    end else begin : g_pc_loop
        // Generic-width population count.
        always_comb begin
            pending_d = '0;
            for (int i = 0; i < Depth; i++) begin
                pending_d = pending_d + (ADDR_W + 1)'(busy_d[i]);
            end
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = pending_q;

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .rd_addr_i (addr),
            .reg_data_i(regs_q[addr]),
            .busy_i    (busy_q[addr]),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy_o (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: vector table plus hand sequences, checked through an expectation queue.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data, nb_rd_data;
    logic [NR-1:0]     rd_busy, nb_rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              flush;
    logic [31:0]       busy_vec, nb_busy_vec;
    logic [AW:0]       pending_cnt, nb_pending_cnt;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec), .pending_cnt(pending_cnt)
    );

    // Same stimulus into a non-bypassing copy.
    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_vec(nb_busy_vec),
        .pending_cnt(nb_pending_cnt)
    );

    typedef enum int {KRd0, KRd1, KBusy, KNb0, KBvec, KCnt} kind_t;
    typedef struct {
        kind_t       k;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] enb;
        logic [1:0]  eb;
        logic [31:0] ebv;
        logic [5:0]  ecnt;
    } vec_t;
    vec_t tbl[15];

    int total = 0;
    int bad   = 0;

    task automatic push(input kind_t k, input logic [31:0] e, input string n);
        exp_t x;
        x.k = k;
        x.exp = e;
        x.name = n;
        exp_q.push_back(x);
    endtask

    // Pop every queued expectation and compare against the live DUT outputs.
    task automatic check_q();
        exp_t x;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            case (x.k)
                KRd0:    got = rd_data[31:0];
                KRd1:    got = rd_data[63:32];
                KBusy:   got = {30'd0, rd_busy};
                KNb0:    got = nb_rd_data[31:0];
                KBvec:   got = busy_vec;
                default: got = {26'd0, pending_cnt};
            endcase
            total++;
            if (got !== x.exp) begin
                bad++;
                $display("FAIL %s got=%h want=%h", x.name, got, x.exp);
            end
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    initial begin
        //          we wa  wd            ie ia fl a0 a1  e0            e1            enb           eb     ebv         cnt
        tbl[0]  = '{1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0,      6'd0};
        tbl[1]  = '{0, 0, 32'h0,        0, 0, 0, 7, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0,      6'd0};
        tbl[2]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 7, 32'h0,        32'hDEADBEEF, 32'h0,        2'b00, 32'h0,      6'd0};
        tbl[3]  = '{0, 0, 32'h0,        1, 3, 0, 3, 0, 32'h0,        32'h0,        32'h0,        2'b00, 32'h8,      6'd1};
        tbl[4]  = '{0, 0, 32'h0,        0, 0, 0, 3, 0, 32'h0,        32'h0,        32'h0,        2'b01, 32'h8,      6'd1};
        tbl[5]  = '{1, 3, 32'h55,       0, 0, 0, 3, 3, 32'h55,       32'h55,       32'h0,        2'b00, 32'h0,      6'd0};
        tbl[6]  = '{0, 0, 32'h0,        0, 0, 0, 3, 3, 32'h55,       32'h55,       32'h55,       2'b00, 32'h0,      6'd0};
        tbl[7]  = '{0, 0, 32'h0,        1, 9, 0, 9, 3, 32'h0,        32'h55,       32'h0,        2'b00, 32'h200,    6'd1};
        tbl[8]  = '{1, 9, 32'hA5A5,     1, 9, 0, 9, 9, 32'hA5A5,     32'hA5A5,     32'h0,        2'b00, 32'h200,    6'd1};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 0, 9, 3, 32'hA5A5,     32'h55,       32'hA5A5,     2'b01, 32'h200,    6'd1};
        tbl[10] = '{1, 9, 32'h1111,     1, 1, 0, 9, 1, 32'h1111,     32'h0,        32'hA5A5,     2'b00, 32'h2,      6'd1};
        tbl[11] = '{0, 0, 32'h0,        1, 2, 0, 1, 2, 32'h0,        32'h0,        32'h0,        2'b01, 32'h6,      6'd2};
        tbl[12] = '{0, 0, 32'h0,        1, 4, 0, 2, 4, 32'h0,        32'h0,        32'h0,        2'b01, 32'h16,     6'd3};
        tbl[13] = '{1, 5, 32'h1234,     1, 6, 1, 6, 4, 32'h0,        32'h0,        32'h0,        2'b10, 32'h0,      6'd0};
        tbl[14] = '{0, 0, 32'h0,        0, 0, 0, 6, 5, 32'h0,        32'h1234,     32'h0,        2'b00, 32'h0,      6'd0};

        idle();
        rd_addr = {5'd0, 5'd7};

        // Initial asynchronous reset, observed before any clock edge.
        #1 rst = 1'b0;
        #1;
        push(KRd0, 32'h0, "init_rd0");
        push(KBusy, 32'h0, "init_busy");
        push(KBvec, 32'h0, "init_bvec");
        push(KCnt, 32'h0, "init_cnt");
        check_q();
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            iss_en = tbl[i].ie; iss_addr = tbl[i].ia; flush = tbl[i].fl;
            rd_addr = {tbl[i].a1, tbl[i].a0};
            push(KRd0, tbl[i].e0, $sformatf("v%0d_rd0", i));
            push(KRd1, tbl[i].e1, $sformatf("v%0d_rd1", i));
            push(KNb0, tbl[i].enb, $sformatf("v%0d_nb_rd0", i));
            push(KBusy, {30'd0, tbl[i].eb}, $sformatf("v%0d_rd_busy", i));
            @(negedge clk);
            check_q();
            push(KBvec, tbl[i].ebv, $sformatf("v%0d_busy_vec", i));
            push(KCnt, {26'd0, tbl[i].ecnt}, $sformatf("v%0d_pending_cnt", i));
            @(posedge clk); #1;
            check_q();
        end

        // Mid-run reset: r5 holds 0x1234, r8 pending; reset must clear all without a clock.
        idle();
        iss_en = 1'b1; iss_addr = 5'd8;
        @(posedge clk); #1;
        idle();
        rd_addr = {5'd8, 5'd5};
        @(negedge clk);
        push(KRd0, 32'h1234, "pre_rst_rd0");
        push(KBusy, 32'h2, "pre_rst_busy");
        push(KCnt, 32'h1, "pre_rst_cnt");
        check_q();
        #1 rst = 1'b0;
        #1;
        push(KRd0, 32'h0, "rst_rd0");
        push(KNb0, 32'h0, "rst_nb_rd0");
        push(KBusy, 32'h0, "rst_busy");
        push(KBvec, 32'h0, "rst_bvec");
        push(KCnt, 32'h0, "rst_cnt");
        check_q();
        @(posedge clk); #1;
        rst = 1'b1;

        // Writes resume after reset.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE;
        @(posedge clk); #1;
        idle();
        push(KRd0, 32'hCAFE, "post_rst_rd0");
        push(KNb0, 32'hCAFE, "post_rst_nb_rd0");
        check_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
